fp_mul_booth_seq: RTL
=====================

Name: fp_mul_booth_seq

Overview:
- Sequential radix-4 Booth mantissa multiplier for the single-precision FP multiply path.
- Produces the full 48-bit significand product, frc_Z_full, that the normalization stage consumes.
- Sits between operand unpack (sign/exponent/hidden-bit extraction) and norm.
- Trades the combinational array for one Booth digit per cycle, with valid/ready handshakes on both sides.
- Carries an opaque sideband tag (sign, exponent sum, r_mode) alongside the product.

Parameters:
MANT_W, 24, significand width including hidden bit
TAG_W, 12, width of opaque sideband passed through unchanged
STEPS, (MANT_W+2)/2 = 13, Booth digits per operation (localparam, derived)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous abort of any operation in flight
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
hid_X  input  1  hidden bit of X (0 when exponent field is 0, i.e. subnormal/zero treated as zero-lead)
frc_X  input  23  fraction of X
hid_Y  input  1  hidden bit of Y
frc_Y  input  23  fraction of Y
tag_in  input  TAG_W  sideband captured with the operands
out_valid  output  1  product valid
out_ready  input  1  downstream (norm) accepts product
frc_Z_full  output  48  unsigned product {hid_X,frc_X}*{hid_Y,frc_Y}
tag_out  output  TAG_W  tag_in captured at accept

Behaviour:
- Clock/reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE, in_ready=1 the following cycle, out_valid=0, frc_Z_full=0, tag_out=0, counter=0. Reset mid-CALC or mid-DONE discards the operation; no output is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A={hid_X,frc_X} and B={hid_Y,frc_Y}, zero-extended to MANT_W+2 bits with an implicit B[-1]=0.
  - Also latch tag_in, clear the accumulator, set cnt=0, go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle recode digit i=cnt from {B[2i+1],B[2i],B[2i-1]}: 000/111→0; 001/010→+1; 011→+2; 100→−2; 101/110→−1.
  - Add digit*A*4^i into the signed accumulator; accumulator width is 2*MANT_W+2 = 50 bits, two's complement.
  - cnt increments each cycle; when cnt==STEPS-1 the next state is DONE.
- DONE:
  - out_valid=1; frc_Z_full = accumulator[47:0], exact and non-negative; tag_out is stable.
  - Hold all outputs stable while out_ready=0.
  - On out_ready=1: go to IDLE, out_valid=0 on the next cycle.
  - No new accept occurs in the same cycle as the output handshake; in_ready is asserted only in IDLE.
- Latency: out_valid rises exactly STEPS (13) rising edges after the accept edge. Throughput: one operation per STEPS+2 cycles minimum.
- flush=1 at an edge (rst_n=1): forces IDLE and out_valid=0, and drops the result. Outputs frc_Z_full/tag_out keep their last value. flush has priority over in_valid and out_ready in the same cycle.
- Inputs are sampled only at the accept edge; input changes during CALC have no effect.
- Boundary conditions:
  - hid=0 with frc=0 (zero/subnormal-flushed operand) still runs the full STEPS cycles and yields 0.
  - Max×max yields 0xFFFFFE000001; no overflow beyond bit 47 is possible.
- Assertions (bound checker):
  - out_valid → frc_Z_full == latched A*B.
  - out_valid && !out_ready → outputs stable next cycle.
  - in_ready and out_valid are never both 1.
  - cnt < STEPS.

Decomposition:
- Shared package fp_mul_pkg:
  - MANT_W and FRAC_W=23.
  - booth_digit_e enum (ZERO, POS1, POS2, NEG1, NEG2).
  - state_e (IDLE, CALC, DONE).
  - Function booth_recode(logic [2:0]) → booth_digit_e.
- Sub-module fp_mul_booth_pp (combinational): takes A and a digit, returns the signed (MANT_W+2)-bit partial product. Instantiated once; fp_mul_booth_seq holds the FSM, counter, accumulator and handshake.

Test Plan:
- Accept hid=1/frc 0x000000 × hid=1/frc 0x000000 → after 13 cycles out_valid=1, frc_Z_full=0x400000000000, tag_out==tag_in.
- hid=1/0x7FFFFF × hid=1/0x7FFFFF → frc_Z_full=0xFFFFFE000001.
- hid=1/0x2DF854 × hid=1/0x490FDB, then hid=0/0x2DF854 × hid=1/0x490FDB → frc_Z_full==24'hADF854*24'hC90FDB, then ==24'h2DF854*24'hC90FDB; each takes 13 cycles.
- X=hid 1/frc 0 × random Y: frc_Z_full[47:46]==2'b01 and [45:23]==frc_Y. X=hid 0/frc 0 → frc_Z_full==0.
- Hold out_ready=0 for 5 cycles in DONE → out_valid and frc_Z_full stable, in_ready=0. Release → in_ready=1 next cycle, back-to-back op accepted.
- Assert rst_n=0 at cnt=6, and separately flush=1 at cnt=6 → next cycle out_valid=0 and in_ready=1. No out_valid appears for the aborted op; a following op returns the correct product.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the FP multiply mantissa path.
// Radix-4 Booth recoding lives here so any stage can reuse it.
package fp_mul_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned FRAC_W = 23;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_e;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    // bits = {B[2i+1], B[2i], B[2i-1]}
    function automatic booth_digit_e booth_recode(input logic [2:0] bits);
        booth_digit_e d;
        case (bits)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fp_mul_booth_pp.sv
// Combinational Booth partial-product generator: digit * A as a
// two's-complement value wide enough for +/-2*A.
module fp_mul_booth_pp
    import fp_mul_pkg::*;
#(
    parameter int unsigned MANT_W = fp_mul_pkg::MANT_W
) (
    input  logic [MANT_W-1:0] a,
    input  booth_digit_e      digit,
    output logic signed [MANT_W+1:0] pp
);

    logic [MANT_W+1:0] a1;
    logic [MANT_W+1:0] a2;

    assign a1 = {2'b00, a};
    assign a2 = {1'b0, a, 1'b0};

    always_comb begin
        pp = '0;
        case (digit)
            POS1:    pp = a1;
            POS2:    pp = a2;
            NEG1:    pp = -a1;
            NEG2:    pp = -a2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth significand multiplier, one digit per cycle,
// valid/ready on both sides; produces the full 48-bit product for norm.
module fp_mul_booth_seq
    import fp_mul_pkg::*;
#(
    parameter int unsigned MANT_W = fp_mul_pkg::MANT_W,
    parameter int unsigned TAG_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  hid_X,
    input  logic [MANT_W-2:0]     frc_X,
    input  logic                  hid_Y,
    input  logic [MANT_W-2:0]     frc_Y,
    input  logic [TAG_W-1:0]      tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*MANT_W-1:0]   frc_Z_full,
    output logic [TAG_W-1:0]      tag_out
);

    localparam int unsigned STEPS = (MANT_W + 2) / 2;
    localparam int unsigned CNT_W = $clog2(STEPS);
    localparam int unsigned ACC_W = 2 * MANT_W + 2;

    state_e state, state_nxt;

    logic [MANT_W-1:0]  a_q;
    logic [MANT_W-1:0]  b_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic [MANT_W+2:0]  b_ext;
    logic [CNT_W:0]     shamt;
    booth_digit_e       digit;
    logic signed [MANT_W+1:0] pp;
    logic               last;
    logic               accept;

    // Zero-extended B with the implicit B[-1]=0 at bit 0
    assign b_ext  = {2'b00, b_q, 1'b0};
    assign shamt  = {cnt, 1'b0};
    assign digit  = booth_recode(b_ext[shamt +: 3]);
    assign last   = (cnt == CNT_W'(STEPS - 1));
    assign accept = in_valid && in_ready;

    fp_mul_booth_pp #(.MANT_W(MANT_W)) u_pp (
        .a     (a_q),
        .digit (digit),
        .pp    (pp)
    );

    assign acc_nxt = acc + ({{(ACC_W-MANT_W-2){pp[MANT_W+1]}}, pp} << shamt);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Results move to the output registers only on completion, so an
    // aborted operation leaves frc_Z_full/tag_out at their last values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            cnt        <= '0;
            acc        <= '0;
            frc_Z_full <= '0;
            tag_out    <= '0;
        end else if (!flush) begin
            if (accept) begin
                a_q   <= {hid_X, frc_X};
                b_q   <= {hid_Y, frc_Y};
                tag_q <= tag_in;
                cnt   <= '0;
                acc   <= '0;
            end else if (state == CALC) begin
                acc <= acc_nxt;
                if (last) begin
                    frc_Z_full <= acc_nxt[2*MANT_W-1:0];
                    tag_out    <= tag_q;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    a_prod: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> frc_Z_full == (2*MANT_W)'(a_q) * (2*MANT_W)'(b_q));
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready && !flush |=>
            out_valid && $stable(frc_Z_full) && $stable(tag_out));
    a_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));
    a_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        cnt < CNT_W'(STEPS));
    a_top: assert property (@(posedge clk) disable iff (!rst_n)
        state == DONE |-> acc[ACC_W-1:2*MANT_W] == '0);

endmodule
